dp_sink_aux_responder: RTL and testbench

DP_SINK_AUX_RESPONDER -- requirements
Module: dp_sink_aux_responder

---
 rtl/dp_sink_aux_responder.sv | 184 ++++++++++++++++++
 tb/tb_dp_sink_aux_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sink_aux_responder.sv
// DisplayPort sink AUX responder.
// Serves native AUX writes to a 16-byte link-config region at CFG_BASE and native reads from
// that region or from an 8-byte read-only status region at STAT_BASE.
// Optional feature macro DP_SINK_AUX_DEFER_EN: when defined, a legal request accepted while
// Sink_Busy is high is answered with DEFER instead of being serviced.

module dp_sink_aux_responder #(
  parameter logic [19:0] CFG_BASE  = 20'h00100,
  parameter logic [19:0] STAT_BASE = 20'h00200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_VLD,
  input  logic [3:0]  Req_CMD,
  input  logic [19:0] Req_Address,
  input  logic [7:0]  Req_LEN,
  input  logic [7:0]  Req_Data,
  input  logic        Req_Data_VLD,
  input  logic        Sink_Busy,
  input  logic [63:0] Status_In,
  output logic [1:0]  Reply_ACK,
  output logic        Reply_ACK_VLD,
  output logic [7:0]  Reply_Data,
  output logic        Reply_Data_VLD,
  output logic        Busy
);

  typedef enum logic [1:0] {StIdle, StWrData, StAck, StRdData} state_e;

  localparam logic [1:0] AckOk    = 2'b00;
  localparam logic [1:0] AckNack  = 2'b01;
  localparam logic [1:0] AckDefer = 2'b10;

  localparam logic [20:0] CfgLast  = {1'b0, CFG_BASE} + 21'd15;
  localparam logic [20:0] StatLast = {1'b0, STAT_BASE} + 21'd7;

  state_e     state_q, state_d;
  logic [3:0] addr_lo_q, addr_lo_d;  // only the low nibble is needed once legality is known
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ack_q, ack_d;
  logic       rd_go_q, rd_go_d;      // ACK state continues into RD_DATA
  logic       stat_sel_q, stat_sel_d;
  logic [7:0] cfg_q [16];

  logic [20:0] span_end;
  logic        in_cfg, in_stat, len_ok, is_wr, is_rd;
  logic        wr_legal, rd_legal, defer;
  logic        wr_en;
  logic [3:0]  cur_lo;
  logic [3:0]  cfg_idx;
  logic [2:0]  stat_idx;

  // Request decode; the 21-bit span end keeps Address+LEN from wrapping into a region.
  always_comb begin
    span_end = {1'b0, Req_Address} + {13'b0, Req_LEN};
    in_cfg   = (Req_Address >= CFG_BASE) && (span_end <= CfgLast);
    in_stat  = (Req_Address >= STAT_BASE) && (span_end <= StatLast);
    len_ok   = (Req_LEN <= 8'd15);
    is_wr    = (Req_CMD == 4'b1000);
    is_rd    = (Req_CMD == 4'b1001);
    wr_legal = is_wr && len_ok && in_cfg;
    rd_legal = is_rd && len_ok && (in_cfg || in_stat);
  end

`ifdef DP_SINK_AUX_DEFER_EN
  assign defer = Sink_Busy;
`else
  logic unused_sink_busy;
  assign unused_sink_busy = Sink_Busy;
  assign defer = 1'b0;
`endif

  // Byte offset of the current transfer within its region (regions are base-relative).
  always_comb begin
    cur_lo   = addr_lo_q + cnt_q;
    cfg_idx  = cur_lo - CFG_BASE[3:0];
    stat_idx = cur_lo[2:0] - STAT_BASE[2:0];
  end

  // Next-state and transfer control.
  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    rd_go_d    = rd_go_q;
    stat_sel_d = stat_sel_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Req_VLD) begin
          addr_lo_d  = Req_Address[3:0];
          len_d      = Req_LEN[3:0];
          cnt_d      = 4'd0;
          stat_sel_d = in_stat;
          rd_go_d    = 1'b0;
          if (wr_legal && !defer) begin
            state_d = StWrData;
          end else begin
            state_d = StAck;
            if (!(wr_legal || rd_legal)) begin
              ack_d = AckNack;
            end else if (defer) begin
              ack_d = AckDefer;
            end else begin
              ack_d   = AckOk;
              rd_go_d = 1'b1;
            end
          end
        end
      end
      StWrData: begin
        if (Req_Data_VLD) begin
          wr_en = 1'b1;
          if (cnt_q == len_q) begin
            state_d = StAck;
            ack_d   = AckOk;
            rd_go_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StAck: begin
        cnt_d   = 4'd0;
        state_d = rd_go_q ? StRdData : StIdle;
      end
      StRdData: begin
        if (cnt_q == len_q) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_lo_q  <= 4'd0;
      len_q      <= 4'd0;
      cnt_q      <= 4'd0;
      ack_q      <= AckOk;
      rd_go_q    <= 1'b0;
      stat_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rd_go_q    <= rd_go_d;
      stat_sel_q <= stat_sel_d;
    end
  end

  // Link-config byte storage; cleared by reset so aborted writes leave nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        cfg_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      cfg_q[cfg_idx] <= Req_Data;
    end
  end

  // Reply outputs; status bytes are taken live from Status_In in the cycle they are sent.
  always_comb begin
    Reply_ACK      = ack_q;
    Reply_ACK_VLD  = (state_q == StAck);
    Reply_Data_VLD = (state_q == StRdData);
    Busy           = (state_q != StIdle);
    Reply_Data     = 8'h00;
    if (state_q == StRdData) begin
      Reply_Data = stat_sel_q ? Status_In[{stat_idx, 3'b000} +: 8] : cfg_q[cfg_idx];
    end
  end

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Self-checking bench for dp_sink_aux_responder: table-driven AUX requests with a
// cycle-stamped scoreboard of expected reply pulses and read bytes.
module tb_dp_sink_aux_responder;

  localparam logic [19:0] CFG_A  = 20'h00100;
  localparam logic [19:0] STAT_A = 20'h00200;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req_VLD;
  logic [3:0]  Req_CMD;
  logic [19:0] Req_Address;
  logic [7:0]  Req_LEN;
  logic [7:0]  Req_Data;
  logic        Req_Data_VLD;
  logic        Sink_Busy;
  logic [63:0] Status_In;
  logic [1:0]  Reply_ACK;
  logic        Reply_ACK_VLD;
  logic [7:0]  Reply_Data;
  logic        Reply_Data_VLD;
  logic        Busy;

  dp_sink_aux_responder #(
    .CFG_BASE  (CFG_A),
    .STAT_BASE (STAT_A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .Req_VLD        (Req_VLD),
    .Req_CMD        (Req_CMD),
    .Req_Address    (Req_Address),
    .Req_LEN        (Req_LEN),
    .Req_Data       (Req_Data),
    .Req_Data_VLD   (Req_Data_VLD),
    .Sink_Busy      (Sink_Busy),
    .Status_In      (Status_In),
    .Reply_ACK      (Reply_ACK),
    .Reply_ACK_VLD  (Reply_ACK_VLD),
    .Reply_Data     (Reply_Data),
    .Reply_Data_VLD (Reply_Data_VLD),
    .Busy           (Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [7:0]  len;
    logic        busy;
    logic [1:0]  ack;
    logic [7:0]  wbase;
    logic        inject;
  } vec_t;

  exp_t       ackq[$];
  exp_t       datq[$];
  logic [7:0] mcfg [16];
  int         vectors = 0;
  int         errors = 0;
  vec_t       vt [17];

  task automatic push_ack(input int c, input logic [1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = {6'b0, v};
    ackq.push_back(e);
  endtask

  task automatic push_dat(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    datq.push_back(e);
  endtask

  function automatic logic [7:0] model_rd(input logic [19:0] a);
    int idx;
    if (a >= CFG_A && a <= CFG_A + 20'd15) begin
      idx = int'(a) - int'(CFG_A);
      return mcfg[idx];
    end
    idx = int'(a) - int'(STAT_A);
    return Status_In[idx*8 +: 8];
  endfunction

  // Scoreboard: every reply pulse must match the head of its queue, value and cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (Reply_ACK_VLD && Reply_Data_VLD) begin
      errors++;
      $display("FAIL overlap: Reply_ACK_VLD and Reply_Data_VLD both 1 at cycle %0d, required exclusive", cyc);
    end
    if (!Reply_Data_VLD && Reply_Data !== 8'h00) begin
      errors++;
      $display("FAIL idle_data: Reply_Data=%h at cycle %0d with VLD low, required 00", Reply_Data, cyc);
    end
    if (Reply_ACK_VLD) begin
      vectors++;
      if (ackq.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: Reply_ACK=%b at cycle %0d, required no pulse", Reply_ACK, cyc);
      end else begin
        e = ackq.pop_front();
        if (Reply_ACK !== e.val[1:0] || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack: got %b at cycle %0d, required %b at cycle %0d",
                   Reply_ACK, cyc, e.val[1:0], e.cyc);
        end
      end
    end
    if (Reply_Data_VLD) begin
      vectors++;
      if (datq.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected: Reply_Data=%h at cycle %0d, required no data", Reply_Data, cyc);
      end else begin
        e = datq.pop_front();
        if (Reply_Data !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL data: got %h at cycle %0d, required %h at cycle %0d",
                   Reply_Data, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    @(negedge clk);
    vectors++;
    if ({Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy} !== 13'd0) begin
      errors++;
      $display("FAIL %s: ack=%b ack_vld=%b data=%h data_vld=%b busy=%b, required all zero",
               name, Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!Busy && ackq.size() == 0 && datq.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ackq.size() != 0 || datq.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d ack and %0d data replies outstanding, required 0",
               name, ackq.size(), datq.size());
      ackq.delete();
      datq.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [1:0] code;
    logic [7:0] d;
    int n, m;
    code = v.ack;
`ifdef DP_SINK_AUX_DEFER_EN
    if (v.busy && code == 2'b00) code = 2'b10;
`endif
    @(posedge clk); #1;
    n = cyc;
    Req_VLD = 1'b1; Req_CMD = v.cmd; Req_Address = v.addr; Req_LEN = v.len; Sink_Busy = v.busy;
    if (code != 2'b00 || v.cmd != 4'h8) push_ack(n + 1, code);
    if (code == 2'b00 && v.cmd == 4'h9) begin
      for (int k = 0; k <= int'(v.len); k++) push_dat(n + 2 + k, model_rd(v.addr + 20'(k)));
    end
    @(posedge clk); #1;
    Req_VLD = 1'b0; Sink_Busy = 1'b0;
    vectors++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL vec%0d busy: Busy=%b after request, required 1", id, Busy);
    end
    if (v.cmd == 4'h8) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        if (k == 1) begin
          Req_Data_VLD = 1'b0;
          @(posedge clk); #1;
        end
        d = v.wbase + 8'(k * 17);
        Req_Data_VLD = 1'b1; Req_Data = d; m = cyc;
        if (code == 2'b00) begin
          mcfg[int'(v.addr) - int'(CFG_A) + k] = d;
          if (k == int'(v.len)) push_ack(m + 1, 2'b00);
        end
        @(posedge clk); #1;
      end
      Req_Data_VLD = 1'b0;
    end
    if (v.inject) begin
      // A new header and a data byte during RD_DATA must be ignored.
      @(posedge clk); #1;
      Req_VLD = 1'b1; Req_CMD = 4'h8; Req_Address = CFG_A; Req_LEN = 8'd0;
      Req_Data_VLD = 1'b1; Req_Data = 8'hEE;
      @(posedge clk); #1;
      Req_VLD = 1'b0;
      @(posedge clk); #1;
      Req_Data_VLD = 1'b0;
    end
    drain($sformatf("vec%0d", id));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    vec_t v;
    reset = 1'b1;
    Req_VLD = 1'b0; Req_CMD = 4'h0; Req_Address = 20'h0; Req_LEN = 8'h0;
    Req_Data = 8'h0; Req_Data_VLD = 1'b0; Sink_Busy = 1'b0;
    Status_In = 64'h0706050403020100;
    for (int i = 0; i < 16; i++) mcfg[i] = 8'h00;

    //           cmd    addr       len    busy  ack    wbase  inject
    vt[0]  = '{4'h8, 20'h00100, 8'd3,  1'b0, 2'b00, 8'h11, 1'b0};  // write 11,22,33,44
    vt[1]  = '{4'h9, 20'h00100, 8'd3,  1'b0, 2'b00, 8'h00, 1'b0};  // readback
    vt[2]  = '{4'h9, 20'h00200, 8'd7,  1'b0, 2'b00, 8'h00, 1'b0};  // status 00..07
    vt[3]  = '{4'h9, 20'h0010E, 8'd2,  1'b0, 2'b01, 8'h00, 1'b0};  // crosses CFG end
    vt[4]  = '{4'h8, 20'h00200, 8'd0,  1'b0, 2'b01, 8'h5A, 1'b0};  // write to STAT
    vt[5]  = '{4'h1, 20'h00100, 8'd0,  1'b0, 2'b01, 8'h00, 1'b0};  // I2C read
    vt[6]  = '{4'h8, 20'h0010C, 8'd3,  1'b0, 2'b00, 8'hA0, 1'b0};  // write ending at CFG end
    vt[7]  = '{4'h9, 20'h00100, 8'd15, 1'b0, 2'b00, 8'h00, 1'b0};  // whole CFG
    vt[8]  = '{4'h9, 20'h000FF, 8'd0,  1'b0, 2'b01, 8'h00, 1'b0};  // just below CFG
    vt[9]  = '{4'h9, 20'h00207, 8'd0,  1'b0, 2'b00, 8'h00, 1'b0};  // last STAT byte
    vt[10] = '{4'h9, 20'h00206, 8'd2,  1'b0, 2'b01, 8'h00, 1'b0};  // crosses STAT end
    vt[11] = '{4'h9, 20'h00100, 8'd16, 1'b0, 2'b01, 8'h00, 1'b0};  // LEN > 15
    vt[12] = '{4'h9, 20'hFFFFF, 8'd15, 1'b0, 2'b01, 8'h00, 1'b0};  // would wrap in 20 bits
    vt[13] = '{4'hA, 20'h00100, 8'd0,  1'b0, 2'b01, 8'h00, 1'b0};  // native, not rd/wr
    vt[14] = '{4'h9, 20'h00200, 8'd1,  1'b1, 2'b00, 8'h00, 1'b0};  // Sink_Busy read
    vt[15] = '{4'h8, 20'h00105, 8'd0,  1'b1, 2'b00, 8'h77, 1'b0};  // Sink_Busy write
    vt[16] = '{4'h9, 20'h00200, 8'd3,  1'b0, 2'b00, 8'h00, 1'b1};  // ignored mid-read header

    repeat (2) @(posedge clk);
    check_idle("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    // Full CFG readback after all writes.
    v = '{4'h9, 20'h00100, 8'd15, 1'b0, 2'b00, 8'h00, 1'b0};
    run_vec(v, 100);

    // Reply_ACK holds the last code between pulses.
    v = '{4'h1, 20'h00200, 8'd0, 1'b0, 2'b01, 8'h00, 1'b0};
    run_vec(v, 101);
    @(negedge clk);
    vectors++;
    if (Reply_ACK !== 2'b01) begin
      errors++;
      $display("FAIL ack_hold: Reply_ACK=%b between pulses, required 01", Reply_ACK);
    end

    // Reset during the third byte of an 8-byte CFG read.
    @(posedge clk); #1;
    n = cyc;
    Req_VLD = 1'b1; Req_CMD = 4'h9; Req_Address = 20'h00100; Req_LEN = 8'd7;
    push_ack(n + 1, 2'b00);
    push_dat(n + 2, model_rd(20'h00100));
    push_dat(n + 3, model_rd(20'h00101));
    @(posedge clk); #1;
    Req_VLD = 1'b0;
    for (int i = 0; i < 10 && cyc < n + 4; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    check_idle("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mcfg[i] = 8'h00;
    drain("reset_abort");

    v = '{4'h9, 20'h00100, 8'd15, 1'b0, 2'b00, 8'h00, 1'b0};
    run_vec(v, 200);
    v = '{4'h8, 20'h00108, 8'd1, 1'b0, 2'b00, 8'h3C, 1'b0};
    run_vec(v, 201);
    v = '{4'h9, 20'h00107, 8'd2, 1'b0, 2'b00, 8'h00, 1'b0};
    run_vec(v, 202);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
